// File: rtl/timebase_stb_gen.sv
// timebase_stb_gen
//   Divides i_clk into a trimmable 1 Hz timebase and generates an auto-accelerating
//   time-set strobe while the set button is held (SLOW -> FAST -> TURBO).
// Ports
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_en           count enable; low freezes the timebase and timeset counters
//   i_set_hold     set button held (synchronised/debounced upstream)
//   i_fast_set     press enters FAST directly (sampled only when leaving IDLE)
//   i_trim         signed period trim in cycles, added to SYS_CLK_HZ
//   i_trim_load    capture i_trim into the shadow register
//   o_1hz_clk      ~50% duty 1 Hz square wave
//   o_1hz_stb      one-cycle pulse per trimmed second
//   o_timeset_stb  one-cycle pulse per set increment
//   o_set_rate     0 IDLE, 1 SLOW, 2 FAST, 3 TURBO
module timebase_stb_gen #(
  parameter int unsigned SYS_CLK_HZ   = 50_000_000,
  parameter int unsigned SLOW_SET_HZ  = 2,
  parameter int unsigned FAST_SET_HZ  = 5,
  parameter int unsigned TURBO_SET_HZ = 20,
  parameter int unsigned ACCEL_CNT    = 4,
  parameter int unsigned TURBO_CNT    = 10,
  parameter int unsigned TRIM_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic              i_set_hold,
  input  logic              i_fast_set,
  input  logic [TRIM_W-1:0] i_trim,
  input  logic              i_trim_load,
  output logic              o_1hz_clk,
  output logic              o_1hz_stb,
  output logic              o_timeset_stb,
  output logic [1:0]        o_set_rate
);

  localparam int unsigned DIV_S   = SYS_CLK_HZ / SLOW_SET_HZ;
  localparam int unsigned DIV_F   = SYS_CLK_HZ / FAST_SET_HZ;
  localparam int unsigned DIV_T   = SYS_CLK_HZ / TURBO_SET_HZ;
  localparam int unsigned DIV_SF  = (DIV_S > DIV_F) ? DIV_S : DIV_F;
  localparam int unsigned DIV_MAX = (DIV_SF > DIV_T) ? DIV_SF : DIV_T;
  localparam int unsigned SEC_W   = $clog2(SYS_CLK_HZ + 2 ** (TRIM_W - 1));
  // One extra bit so period arithmetic on the signed trim never overflows.
  localparam int unsigned PW      = SEC_W + 1;
  localparam int unsigned SW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned ACC_MAX = (ACCEL_CNT > TURBO_CNT) ? ACCEL_CNT : TURBO_CNT;
  localparam int unsigned AW      = $clog2(ACC_MAX + 1);

  if (SLOW_SET_HZ == 0 || FAST_SET_HZ == 0 || TURBO_SET_HZ == 0) begin : g_chk_rate
    $error("timebase_stb_gen: set rates must be non-zero");
  end
  if (SYS_CLK_HZ < 2 * TURBO_SET_HZ) begin : g_chk_turbo
    $error("timebase_stb_gen: SYS_CLK_HZ must be at least 2*TURBO_SET_HZ");
  end
  if (2 ** (TRIM_W - 1) >= SYS_CLK_HZ / 2) begin : g_chk_trim
    $error("timebase_stb_gen: trim range must stay below SYS_CLK_HZ/2");
  end
  if (ACCEL_CNT < 1 || TURBO_CNT < 1) begin : g_chk_acc
    $error("timebase_stb_gen: ACCEL_CNT and TURBO_CNT must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // 1 Hz timebase
  // ---------------------------------------------------------------------------
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [TRIM_W-1:0] trim_shadow_q, trim_shadow_d;
  logic [TRIM_W-1:0] trim_active_q, trim_active_d;
  logic              hz_clk_q, hz_clk_d;
  logic              hz_stb_q, hz_stb_d;
  logic [PW-1:0]     period;
  logic [PW-1:0]     sec_next;

  always_comb begin
    period        = PW'(SYS_CLK_HZ) + {{(PW - TRIM_W){trim_active_q[TRIM_W-1]}}, trim_active_q};
    sec_next      = {1'b0, sec_cnt_q} + PW'(1);
    sec_cnt_d     = sec_cnt_q;
    hz_clk_d      = hz_clk_q;
    hz_stb_d      = 1'b0;
    trim_active_d = trim_active_q;
    // A load coinciding with a wrap is captured here, but the wrap below takes the old shadow.
    trim_shadow_d = i_trim_load ? i_trim : trim_shadow_q;
    if (i_en) begin
      if (sec_next == period) begin
        sec_cnt_d     = '0;
        hz_stb_d      = 1'b1;
        hz_clk_d      = 1'b1;
        trim_active_d = trim_shadow_q;
      end else begin
        sec_cnt_d = sec_next[SEC_W-1:0];
        if (sec_next == (period >> 1)) hz_clk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sec_cnt_q     <= '0;
      trim_shadow_q <= '0;
      trim_active_q <= '0;
      hz_clk_q      <= 1'b1;
      hz_stb_q      <= 1'b0;
    end else begin
      sec_cnt_q     <= sec_cnt_d;
      trim_shadow_q <= trim_shadow_d;
      trim_active_q <= trim_active_d;
      hz_clk_q      <= hz_clk_d;
      hz_stb_q      <= hz_stb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeset FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle = 2'd0, StSlow = 2'd1, StFast = 2'd2, StTurbo = 2'd3} set_state_e;

  set_state_e    state_q, state_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  logic [AW-1:0] acc_inc;
  logic [SW-1:0] div_m1;
  logic          set_hit;
  logic          ts_stb_q, ts_stb_d;

  always_comb begin
    unique case (state_q)
      StFast:  div_m1 = SW'(DIV_F - 1);
      StTurbo: div_m1 = SW'(DIV_T - 1);
      default: div_m1 = SW'(DIV_S - 1);
    endcase
    set_hit = (set_cnt_q == div_m1);
    acc_inc = acc_cnt_q + AW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      set_cnt_q <= '0;
      acc_cnt_q <= '0;
      ts_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      ts_stb_q  <= ts_stb_d;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    acc_cnt_d = acc_cnt_q;
    if (!i_set_hold) begin
      state_d   = StIdle;
      set_cnt_d = '0;
      acc_cnt_d = '0;
    end else if (i_en) begin
      if (state_q == StIdle) begin
        state_d   = i_fast_set ? StFast : StSlow;
        set_cnt_d = '0;
        acc_cnt_d = '0;
      end else if (set_hit) begin
        set_cnt_d = '0;
        acc_cnt_d = acc_inc;
        unique case (state_q)
          StSlow: if (acc_inc == AW'(ACCEL_CNT)) begin
            state_d   = StFast;
            acc_cnt_d = '0;
          end
          StFast: if (acc_inc == AW'(TURBO_CNT)) begin
            state_d   = StTurbo;
            acc_cnt_d = '0;
          end
          // Terminal: stop counting so the accelerator never wraps.
          default: acc_cnt_d = acc_cnt_q;
        endcase
      end else begin
        set_cnt_d = set_cnt_q + SW'(1);
      end
    end
  end

  // Strobe: entry pulse out of IDLE, then one per divider wrap.
  always_comb begin
    ts_stb_d = i_set_hold && i_en && ((state_q == StIdle) || set_hit);
  end

  assign o_1hz_clk     = hz_clk_q;
  assign o_1hz_stb     = hz_stb_q;
  assign o_timeset_stb = ts_stb_q;
  assign o_set_rate    = state_q;

endmodule

// File: tb/tb_timebase_stb_gen.sv
module tb_timebase_stb_gen;

  localparam int SYS   = 100;
  localparam int ACC   = 2;
  localparam int TRB   = 3;
  localparam int DIV_S = 50;
  localparam int DIV_F = 20;
  localparam int DIV_T = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, hold = 1'b0, fast = 1'b0, load = 1'b0;
  logic [3:0] trim = 4'd0;
  logic       hz_clk, hz_stb, ts_stb;
  logic [1:0] rate;

  timebase_stb_gen #(
    .SYS_CLK_HZ  (SYS),
    .SLOW_SET_HZ (2),
    .FAST_SET_HZ (5),
    .TURBO_SET_HZ(20),
    .ACCEL_CNT   (ACC),
    .TURBO_CNT   (TRB),
    .TRIM_W      (4)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_en         (en),
    .i_set_hold   (hold),
    .i_fast_set   (fast),
    .i_trim       (trim),
    .i_trim_load  (load),
    .o_1hz_clk    (hz_clk),
    .o_1hz_stb    (hz_stb),
    .o_timeset_stb(ts_stb),
    .o_set_rate   (rate)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Reference model state
  int         m_e, m_p, m_shadow, m_h;
  bit         m_clk, m_stb, m_ts, m_ts_on, m_fast;
  logic [1:0] m_rate;

  // Timeset schedule as a pure function of held-and-enabled edges since the press.
  function automatic void ts_expect(input int h, input bit fst, output bit stb,
                                    output logic [1:0] r);
    int se, fe;
    se = fst ? 0 : ACC * DIV_S;
    fe = se + TRB * DIV_F;
    if (!fst && h < se) begin
      stb = (h % DIV_S) == 0;
      r   = 2'd1;
    end else if (h < fe) begin
      stb = ((h - se) % DIV_F) == 0;
      r   = 2'd2;
    end else begin
      stb = ((h - fe) % DIV_T) == 0;
      r   = 2'd3;
    end
  endfunction

  function automatic void model_reset();
    m_e = 0; m_p = SYS; m_shadow = 0; m_h = 0;
    m_clk = 1'b1; m_stb = 1'b0; m_ts = 1'b0; m_ts_on = 1'b0; m_fast = 1'b0;
    m_rate = 2'd0;
    n = 0;
  endfunction

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    n++;
    if (en) begin
      m_e++;
      if (m_e == m_p) begin
        m_e = 0; m_stb = 1'b1; m_clk = 1'b1;
        m_p = SYS + m_shadow;
      end else begin
        m_stb = 1'b0;
        if (m_e == m_p / 2) m_clk = 1'b0;
      end
    end else begin
      m_stb = 1'b0;
    end
    if (load) m_shadow = int'($signed(trim));
    if (!hold) begin
      m_ts_on = 1'b0; m_ts = 1'b0; m_rate = 2'd0;
    end else if (!en) begin
      m_ts = 1'b0;
    end else begin
      if (!m_ts_on) begin
        m_ts_on = 1'b1; m_h = 0; m_fast = fast;
      end else begin
        m_h++;
      end
      ts_expect(m_h, m_fast, m_ts, m_rate);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; hold = 1'b0; fast = 1'b0; load = 1'b0; trim = 4'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({hz_clk, hz_stb, ts_stb, rate} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_async got %b want %b", {hz_clk, hz_stb, ts_stb, rate}, 5'b10000);
    end
    en = 1'b1; hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({hz_clk, hz_stb, ts_stb, rate} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_held got %b want %b", {hz_clk, hz_stb, ts_stb, rate}, 5'b10000);
    end
  endtask

  task automatic test_timebase();
    int cnt = 0;
    int first = 0;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL timebase n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
      if (hz_stb) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    total++;
    if (first != 100 || cnt != 3) begin
      bad++;
      $display("FAIL timebase_sched first=%0d cnt=%0d want first=100 cnt=3", first, cnt);
    end
  endtask

  task automatic test_trim();
    int last = 0;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      load = (i == 10) || (i == 250);
      trim = (i == 10) ? 4'd3 : 4'h8;
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL trim n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
      if (hz_stb) last = n;
    end
    load = 1'b0;
    total++;
    if (last != 398) begin
      bad++;
      $display("FAIL trim_last_strobe got %0d want 398", last);
    end
  endtask

  task automatic test_timeset();
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      hold = (i >= 5);
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL timeset n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
    end
  endtask

  task automatic test_release_fast();
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 220; i++) begin
      hold = ((i >= 5) && (i < 130)) || (i >= 140);
      fast = (i >= 135);
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL release_fast n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
    end
  endtask

  task automatic test_enable();
    int first = 0;
    do_reset();
    for (int i = 1; i <= 160; i++) begin
      en   = !((i >= 41) && (i <= 70));
      hold = (i >= 20);
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL enable n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
      if (hz_stb && first == 0) first = n;
    end
    total++;
    if (first != 130) begin
      bad++;
      $display("FAIL enable_stretch got %0d want 130", first);
    end
  endtask

  task automatic test_async_reset();
    int cnt = 0;
    do_reset();
    en = 1'b1; hold = 1'b1;
    repeat (200) step();
    total++;
    if (rate !== 2'd3) begin
      bad++;
      $display("FAIL pre_reset_turbo got %0d want 3", rate);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({hz_clk, hz_stb, ts_stb, rate} !== 5'b10000) begin
      bad++;
      $display("FAIL async_reset got %b want %b", {hz_clk, hz_stb, ts_stb, rate}, 5'b10000);
    end
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 300; i++) begin
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL after_reset n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
      if (hz_stb && (n % 100 == 0)) cnt++;
    end
    total++;
    if (cnt != 3) begin
      bad++;
      $display("FAIL after_reset_sched got %0d strobes want 3", cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 1; i <= 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) begin
        hold = ~hold;
        fast = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 19) == 0) fast = ~fast;
      load = ($urandom_range(0, 39) == 0);
      trim = 4'($urandom);
      step();
      total++;
      if ({hz_clk, hz_stb, ts_stb, rate} !== {m_clk, m_stb, m_ts, m_rate}) begin
        bad++;
        $display("FAIL random n=%0d got %b want %b", n, {hz_clk, hz_stb, ts_stb, rate},
                 {m_clk, m_stb, m_ts, m_rate});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timebase();
    test_trim();
    test_timeset();
    test_release_fast();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
